upsamp_fir_interp: RTL
======================

// Module: upsamp_fir_interp
// PURPOSE
//  Parametrised polyphase interpolator for the 64QAM modulator I/Q path: upsampling by L and FIR pulse shaping in one block.
//  Each accepted input symbol produces L filtered output samples, using a runtime-loadable coefficient bank.
//  Adds valid/ready flow control, backpressure and optional output saturation, none of which the fixed single-rate UpsampFilter has.
// PARAMETERS
//  L          4   interpolation factor, >=2
//  TAPS       72  prototype filter length; zero-padded internally to TPP*L
//  DW         4   input sample width, signed two's complement
//  CW         8   coefficient width, signed
//  OW         12  output width, signed
//  OUT_SHIFT  0   arithmetic right shift applied to the accumulator before output
//  AW         7   coefficient address width; requires 2**AW >= TAPS
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    in_data is valid this cycle
//  in_ready   out  1    block can accept a symbol this cycle
//  in_data    in   DW   input symbol
//  out_valid  out  1    out_data is valid this cycle
//  out_ready  in   1    downstream accepts out_data this cycle
//  out_data   out  OW   filtered output sample
//  out_phase  out  clog2(L)  polyphase index of out_data, 0..L-1
//  cfg_we     in   1    coefficient write strobe
//  cfg_addr   in   AW   coefficient index, 0..TAPS-1
//  cfg_data   in   CW   coefficient value
//  sat_flag   out  1    sticky overflow flag; present only with UPSAMP_FIR_SAT_EN
// BEHAVIOUR
//  - Reset: clears out_valid, out_data, out_phase, phase counter, delay line, all coefficients and sat_flag. FSM goes to IDLE.
//  - Delay line: x[0..TPP-1], where TPP = ceil(TAPS/L). It shifts only on an input handshake (in_valid & in_ready); x[0] <= in_data.
//  - Phase p output: y = sum over k=0..TPP-1 of h[k*L+p] * x[k]. Taps with index >= TAPS use h = 0.
//  - Width: products are DW+CW bits. The accumulator ACCW = DW+CW+clog2(TPP) never overflows. The result is acc >>> OUT_SHIFT.
//  - FSM states:
//    IDLE: in_ready=1. On input handshake, shift the delay line, load out_data with phase 0, set out_valid, go to EMIT.
//    EMIT: holds out_data/out_phase stable while out_valid & !out_ready.
//      - On output handshake with phase < L-1: load phase+1 the next cycle.
//      - On output handshake with phase == L-1: in_ready=1 in the same cycle (combinational from out_ready).
//        With a simultaneous input handshake, shift and load phase 0 with no bubble; otherwise clear out_valid and go to IDLE.
//  - Latency: input handshake at cycle t gives out_valid=1 with phase 0 at cycle t+1. Sustained rate is 1 output/cycle, 1 input per L cycles.
//  - in_ready is 0 in EMIT except on the last-phase handshake. in_data is ignored when in_ready=0.
//  - Coefficient write: h[cfg_addr] <= cfg_data on the clock edge. cfg_addr >= TAPS is ignored.
//    A write never disturbs a held out_data; the new value is used from the next phase load.
//  - Reset asserted mid-frame: remaining phases are discarded and out_valid drops asynchronously.
// CONFIGURATION
//  UPSAMP_FIR_SAT_EN defined:
//    - Shifted results outside [-2**(OW-1), 2**(OW-1)-1] clamp to the nearest limit.
//    - sat_flag is set on any clamp and stays set until reset.
//  UPSAMP_FIR_SAT_EN undefined:
//    - out_data takes the low OW bits of the shifted result (wrap-around).
//    - The sat_flag port is absent.
// STRUCTURE
//  - Package upsamp_fir_pkg: state enum {IDLE, EMIT}; function tpp(TAPS, L); function accw(DW, CW, TPP); clog2 helper.
//  - Sub-module upsamp_fir_coeff_bank:
//    - 2**AW x CW register file with async reset and a single write port.
//    - Exposes the TPP coefficients of the phase selected by a phase input, combinationally.
//  - Top level: FSM, phase counter, delay line, MAC tree, shift/saturate stage, output register.
// TESTING (L=4, TAPS=8, DW=4, CW=8, OW=12, OUT_SHIFT=0)
//  1. Impulse response:
//     - Stimulus: load h[k]=k+1; input 1 followed by 0,0,...; out_ready=1.
//     - Expect: outputs 1,2,3,4,5,6,7,8, then all 0; out_phase cycles 0,1,2,3.
//  2. Backpressure:
//     - Stimulus: as test 1, with out_ready low for 3 cycles during phase 2.
//     - Expect: out_data holds 3 and in_ready stays 0 for those cycles; the sequence resumes 4,5,... without loss.
//  3. Back-to-back inputs:
//     - Stimulus: in_valid held at 1 with symbols 1,1.
//     - Expect: in_ready pulses only on the phase-3 handshake; no bubble; outputs 1,2,3,4,6,8,10,12.
//  4. Extremes:
//     - Stimulus: all h=127 and repeated input -8, OW=12.
//     - Expect: -2032 with SAT_EN; low 12 bits of the wrapped value without it.
//     - Also: a small OW or large products trigger a clamp, and sat_flag goes and stays 1.
//  5. Runtime coefficient write:
//     - Stimulus: during EMIT, write h[5]=0; also write cfg_addr=100.
//     - Expect: the held output is unchanged; the next frame uses h[5]=0; the write to address 100 has no effect.
//  6. Reset mid-frame:
//     - Stimulus: assert rst during phase 1.
//     - Expect: out_valid=0 immediately; after release, in_ready=1, and an impulse reproduces all zeros because the coefficients were cleared.

Source files
------------

// File: rtl/upsamp_fir_pkg.sv
// Shared types and sizing helpers for the polyphase interpolator.
package upsamp_fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Taps per polyphase branch.
  function automatic int unsigned tpp(input int unsigned taps, input int unsigned l);
    return (taps + l - 1) / l;
  endfunction

  // Accumulator width that cannot overflow for TPP products.
  function automatic int unsigned accw(input int unsigned dw, input int unsigned cw,
                                       input int unsigned n);
    return dw + cw + clog2(n);
  endfunction

endpackage

// File: rtl/upsamp_fir_coeff_bank.sv
// Runtime-loadable coefficient register file; presents the TPP taps of one
// polyphase branch combinationally.
module upsamp_fir_coeff_bank
  import upsamp_fir_pkg::*;
#(
  parameter int unsigned L    = 4,
  parameter int unsigned TAPS = 72,
  parameter int unsigned CW   = 8,
  parameter int unsigned AW   = 7,
  parameter int unsigned TPP  = tpp(TAPS, L),
  parameter int unsigned PW   = clog2(L)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we_i,
  input  logic [AW-1:0]           cfg_addr_i,
  input  logic [CW-1:0]           cfg_data_i,
  input  logic [PW-1:0]           phase_i,
  output logic [TPP-1:0][CW-1:0]  coef_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [CW-1:0] mem_q [DEPTH];

  // Single write port; addresses beyond the prototype length are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (cfg_we_i && (32'(cfg_addr_i) < TAPS)) begin
      mem_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Branch p uses h[k*L+p]; zero padding past TAPS.
  always_comb begin
    coef_o = '0;
    for (int unsigned k = 0; k < TPP; k++) begin
      if ((k * L + 32'(phase_i)) < TAPS) begin
        coef_o[k] = mem_q[AW'(k * L + 32'(phase_i))];
      end
    end
  end

endmodule

// File: rtl/upsamp_fir_interp.sv
// Polyphase upsample-by-L FIR interpolator with valid/ready flow control.
// Define UPSAMP_FIR_SAT_EN for output saturation and the sticky sat_flag port.
module upsamp_fir_interp
  import upsamp_fir_pkg::*;
#(
  parameter int unsigned L         = 4,
  parameter int unsigned TAPS      = 72,
  parameter int unsigned DW        = 4,
  parameter int unsigned CW        = 8,
  parameter int unsigned OW        = 12,
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned AW        = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OW-1:0]         out_data,
  output logic [clog2(L)-1:0]   out_phase,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [CW-1:0]         cfg_data
`ifdef UPSAMP_FIR_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int unsigned TPP    = tpp(TAPS, L);
  localparam int unsigned PW     = clog2(L);
  localparam int unsigned PROD_W = DW + CW;
  localparam int unsigned ACCW   = accw(DW, CW, TPP);
  localparam int unsigned EW     = ((ACCW > OW) ? ACCW : OW) + 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(L - 1);

  state_e                 state_q, state_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic                   out_valid_q, out_valid_d;
  logic [OW-1:0]          out_data_q, out_data_d;
  logic [TPP-1:0][DW-1:0] x_q, x_d;

  logic                   in_ready_c;
  logic                   shift_c;
  logic                   load_c;
  logic [PW-1:0]          load_phase_c;
  logic [TPP-1:0][CW-1:0] coef_c;
  logic signed [PROD_W-1:0] prod_c [TPP];
  logic signed [ACCW-1:0] acc_c;
  logic signed [ACCW-1:0] shifted_c;
  logic signed [EW-1:0]   wide_c;
  logic [OW-1:0]          res_c;

  upsamp_fir_coeff_bank #(
    .L    (L),
    .TAPS (TAPS),
    .CW   (CW),
    .AW   (AW),
    .TPP  (TPP),
    .PW   (PW)
  ) u_coeff_bank (
    .clk        (clk),
    .rst        (rst),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .phase_i    (load_phase_c),
    .coef_o     (coef_c)
  );

  // Frame sequencing: one symbol in, L phases out; last-phase handshake may
  // take the next symbol in the same cycle so there is no bubble.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    out_valid_d  = out_valid_q;
    in_ready_c   = 1'b0;
    shift_c      = 1'b0;
    load_c       = 1'b0;
    load_phase_c = phase_q;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          shift_c      = 1'b1;
          load_c       = 1'b1;
          load_phase_c = '0;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (phase_q == LAST_PHASE) begin
            in_ready_c = 1'b1;
            if (in_valid) begin
              shift_c      = 1'b1;
              load_c       = 1'b1;
              load_phase_c = '0;
            end else begin
              out_valid_d = 1'b0;
              state_d     = IDLE;
            end
          end else begin
            load_c       = 1'b1;
            load_phase_c = phase_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      out_valid_d = 1'b1;
      phase_d     = load_phase_c;
    end
  end

  // Post-shift delay line feeds the MAC so phase 0 sees the new symbol.
  always_comb begin
    x_d = x_q;
    if (shift_c) begin
      x_d[0] = in_data;
      for (int unsigned k = 1; k < TPP; k++) x_d[k] = x_q[k-1];
    end
  end

  always_comb begin
    acc_c = '0;
    for (int unsigned k = 0; k < TPP; k++) begin
      prod_c[k] = PROD_W'($signed(x_d[k])) * PROD_W'($signed(coef_c[k]));
      acc_c     = acc_c + ACCW'(prod_c[k]);
    end
    shifted_c = acc_c >>> OUT_SHIFT;
    wide_c    = EW'(shifted_c);
  end

`ifdef UPSAMP_FIR_SAT_EN
  localparam logic signed [EW-1:0] LIM_HI = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] LIM_LO = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic clamp_c;
  logic sat_q, sat_d;

  always_comb begin
    clamp_c = 1'b0;
    res_c   = wide_c[OW-1:0];
    if (wide_c > LIM_HI) begin
      clamp_c = 1'b1;
      res_c   = LIM_HI[OW-1:0];
    end else if (wide_c < LIM_LO) begin
      clamp_c = 1'b1;
      res_c   = LIM_LO[OW-1:0];
    end
    sat_d = sat_q | (load_c & clamp_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`else
  logic unused_wide_c;

  // Wrap-around: keep the low OW bits.
  assign res_c         = wide_c[OW-1:0];
  assign unused_wide_c = ^wide_c[EW-1:OW];
`endif

  always_comb begin
    out_data_d = out_data_q;
    if (load_c) out_data_d = res_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      x_q         <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      x_q         <= x_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_phase = phase_q;

endmodule
